shift_reg_unit: RTL and testbench

//  Multicycle shift register for the MIPS datapath. It produces shift_reg_output,

---
 rtl/shift_reg_unit.sv | 94 +++++++++
 tb/tb_shift_reg_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/shift_reg_unit.sv
// Multicycle shifter for the MIPS datapath: one bit per clock under a
// start/busy/done handshake. Covers SLL/SRL/SRA/ROR and a plain load.
module shift_reg_unit #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [2:0]         op,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [WIDTH-1:0]   shift_reg_output,
   output logic               busy,
   output logic               done
);

   localparam logic [2:0] OP_SLL = 3'b001;
   localparam logic [2:0] OP_SRL = 3'b010;
   localparam logic [2:0] OP_SRA = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   data_nxt;
   logic [SHAMT_W-1:0] count, count_nxt;
   logic [2:0]         op_q, op_nxt;
   logic               is_shift_op_c;

   // Ops 101-111 are reserved and behave as a load
   assign is_shift_op_c = (op == OP_SLL) || (op == OP_SRL) ||
                          (op == OP_SRA) || (op == OP_ROR);

   // Next-state, datapath and counter update
   always_comb begin
      state_nxt = state;
      data_nxt  = shift_reg_output;
      count_nxt = count;
      op_nxt    = op_q;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               data_nxt  = data_in;
               count_nxt = shamt;
               op_nxt    = op;
               if (is_shift_op_c && (shamt != SHAMT_W'(0)))
                  state_nxt = SHIFT;
               else
                  state_nxt = DONE;
            end else begin
               state_nxt = IDLE;
            end
         end
         SHIFT: begin
            case (op_q)
               OP_SLL:  data_nxt = {shift_reg_output[WIDTH-2:0], 1'b0};
               OP_SRL:  data_nxt = {1'b0, shift_reg_output[WIDTH-1:1]};
               OP_SRA:  data_nxt = {shift_reg_output[WIDTH-1], shift_reg_output[WIDTH-1:1]};
               OP_ROR:  data_nxt = {shift_reg_output[0], shift_reg_output[WIDTH-1:1]};
               default: data_nxt = shift_reg_output;
            endcase
            count_nxt = count - SHAMT_W'(1);
            if (count == SHAMT_W'(1))
               state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, datapath and registered status flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         shift_reg_output <= '0;
         count            <= '0;
         op_q             <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
      end else begin
         state            <= state_nxt;
         shift_reg_output <= data_nxt;
         count            <= count_nxt;
         op_q             <= op_nxt;
         busy             <= (state_nxt == SHIFT);
         done             <= (state_nxt == DONE);
      end
   end

endmodule

// File: tb/tb_shift_reg_unit.sv
// Scoreboard bench for shift_reg_unit: driver queues expected results,
// monitor checks value, done cycle and busy-cycle count on every done pulse.
module tb_shift_reg_unit;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] data_in;
   logic [4:0]  shamt;
   logic [31:0] shift_reg_output;
   logic        busy;
   logic        done;

   typedef struct {
      logic [31:0] result;
      int          done_at;
      int          nbusy;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   pc = 0;
   int   busy_cnt = 0;

   shift_reg_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .start            (start),
      .op               (op),
      .data_in          (data_in),
      .shamt            (shamt),
      .shift_reg_output (shift_reg_output),
      .busy             (busy),
      .done             (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) pc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation
   always @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got done=1 at edge %0d expected no pending op", pc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check({e.name, "_result"}, shift_reg_output, e.result);
               check({e.name, "_done_cycle"}, 32'(pc), 32'(e.done_at));
               check({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(e.nbusy));
            end
            busy_cnt = 0;
         end
      end
   end

   // Drive one accepted start at the next rising edge; call from a negedge
   task automatic issue(input logic [2:0] o, input logic [31:0] d, input logic [4:0] s,
                        input logic [31:0] r, input string name);
      exp_t e;
      int   n;
      n = ((o >= 3'd1) && (o <= 3'd4)) ? int'(s) : 0;
      op = o; data_in = d; shamt = s; start = 1'b1;
      e.result = r; e.done_at = pc + 1 + n; e.nbusy = n; e.name = name;
      sb.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_empty();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL timeout: got %0d pending ops expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      int k;
      reset_n = 1'b0; start = 1'b0; op = 3'd0; data_in = '0; shamt = '0;
      #12;
      check("reset_output", shift_reg_output, 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_done", 32'(done), 32'h0);
      reset_n = 1'b1;
      @(negedge clk);

      issue(3'b001, 32'h00000001, 5'd4, 32'h00000010, "sll4");
      wait_empty();
      issue(3'b011, 32'h80000000, 5'd31, 32'hFFFFFFFF, "sra31");
      wait_empty();
      issue(3'b010, 32'h80000000, 5'd31, 32'h00000001, "srl31");
      wait_empty();
      issue(3'b100, 32'h00000003, 5'd1, 32'h80000001, "ror1");
      wait_empty();
      issue(3'b011, 32'h40000000, 5'd2, 32'h10000000, "sra_pos");
      wait_empty();
      issue(3'b001, 32'hDEADBEEF, 5'd0, 32'hDEADBEEF, "sll0");
      wait_empty();
      issue(3'b000, 32'hDEADBEEF, 5'd7, 32'hDEADBEEF, "load7");
      wait_empty();
      issue(3'b111, 32'h12345678, 5'd9, 32'h12345678, "reserved");
      wait_empty();
      repeat (3) @(negedge clk);
      check("result_hold", shift_reg_output, 32'h12345678);

      // start pulsed mid-shift is ignored, then back-to-back start in DONE
      issue(3'b001, 32'h00000001, 5'd4, 32'h00000010, "sll4_busy");
      @(negedge clk);
      op = 3'b100; data_in = 32'hFFFF0000; shamt = 5'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL wait_done: got done=0 expected done=1");
      end
      issue(3'b010, 32'h000000F0, 5'd4, 32'h0000000F, "b2b_srl4");
      wait_empty();

      // async reset mid-shift discards the operation
      issue(3'b011, 32'h80000000, 5'd31, 32'hFFFFFFFF, "sra31_rst");
      repeat (10) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("midreset_output", shift_reg_output, 32'h0);
      check("midreset_busy", 32'(busy), 32'h0);
      check("midreset_done", 32'(done), 32'h0);
      reset_n = 1'b1;
      void'(sb.pop_back());
      repeat (5) @(negedge clk);
      check("post_reset_busy", 32'(busy), 32'h0);
      check("post_reset_done", 32'(done), 32'h0);
      check("post_reset_output", shift_reg_output, 32'h0);

      issue(3'b100, 32'h00000001, 5'd31, 32'h00000002, "ror31");
      wait_empty();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
